diff_avg_filter: RTL

Parametrised second-difference filter with decimation and a moving-average back end. It takes a signed sample stream, keeps every DECIM-th valid sample and applies y = x[n] − 2·x[n−1] + x[n−2]. It then averages the last 2^AVG_LOG2 differences with a running sum over a circular window buffer. It sits after the input sampler and feeds averaged (or raw) curvature values to downstream logic with a valid strobe.

---
 rtl/diff_avg_pkg.sv | 26 ++
 rtl/avg_window_ram.sv | 46 ++++
 rtl/diff_avg_filter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/diff_avg_pkg.sv
// rtl/diff_avg_pkg.sv - shared state encoding and width helpers for diff_avg_filter
//
// Purpose: holds the filter FSM state type and the functions that derive the
//          difference width (D_W) and running-sum width (S_W) from the
//          parameters, so the top and the bench agree on them.
// Ports:   none (package).
package diff_avg_pkg;

    typedef enum logic [1:0] {
        TAPS = 2'd0,
        WIN  = 2'd1,
        FULL = 2'd2
    } state_t;

    // Second difference of IN_W-bit samples spans at most 4x the input
    // range, so two extra bits always hold it.
    function automatic int d_width(input int in_w);
        return in_w + 2;
    endfunction

    // Sum of 2^avg_log2 differences needs avg_log2 more bits than one difference.
    function automatic int s_width(input int in_w, input int avg_log2);
        return in_w + 2 + avg_log2;
    endfunction

endpackage

// File: rtl/avg_window_ram.sv
// rtl/avg_window_ram.sv - circular window storage with read-before-write and write forwarding
//
// Purpose: DEPTH x W storage for the averaging window. One write port, one
//          registered read port.
// Ports:   CLK            clock
//          wr_en/addr/data write request
//          rd_en/addr     read request; rd_data valid the cycle after
//          rd_data        registered read result
//
// A write is staged for one cycle before it lands in the array. A read on the
// cycle after a write to the same address is served from the staging
// register, so it returns the new value. A read and write to the same address
// on the same edge returns the previous contents.
module avg_window_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 16
) (
    input  logic                     CLK,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0]             mem [DEPTH];
    logic                     pend;
    logic [$clog2(DEPTH)-1:0] pend_addr;
    logic [W-1:0]             pend_data;

    // Contents are deliberately not reset; the filter FSM never consumes an
    // entry it has not written since reset.
    always_ff @(posedge CLK) begin
        if (pend) begin
            mem[pend_addr] <= pend_data;
        end
        pend      <= wr_en;
        pend_addr <= wr_addr;
        pend_data <= wr_data;
        if (rd_en) begin
            rd_data <= (pend && pend_addr == rd_addr) ? pend_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/diff_avg_filter.sv
// rtl/diff_avg_filter.sv - decimating second-difference filter with moving-average output
//
// Purpose: keeps every DECIM-th valid sample, forms d = x0 - 2*x1 + x2 and
//          either passes d through (MODE=1) or averages the last 2^AVG_LOG2
//          values of d with a running sum (MODE=0).
// Ports:   CLK        clock
//          RST        asynchronous active-low reset
//          IN         signed input sample, IN_W bits
//          IN_VALID   IN valid this cycle
//          MODE       0 = averaged, 1 = raw second difference
//          OUT        signed result, IN_W+2 bits
//          OUT_VALID  one-cycle strobe for OUT
//          PRIMED     window full, averages trustworthy
module diff_avg_filter
    import diff_avg_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int DECIM    = 64,
    parameter int AVG_LOG2 = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IN_W-1:0] IN,
    input  logic            IN_VALID,
    input  logic            MODE,
    output logic [IN_W+1:0] OUT,
    output logic            OUT_VALID,
    output logic            PRIMED
);

    localparam int D_W   = d_width(IN_W);
    localparam int S_W   = s_width(IN_W, AVG_LOG2);
    localparam int N     = 1 << AVG_LOG2;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    if (IN_W < 2) begin : g_chk_in_w
        $error("diff_avg_filter: IN_W must be at least 2");
    end
    if (DECIM < 1 || DECIM > 1024) begin : g_chk_decim
        $error("diff_avg_filter: DECIM must be in 1..1024");
    end
    if (AVG_LOG2 < 1 || AVG_LOG2 > 10) begin : g_chk_avg
        $error("diff_avg_filter: AVG_LOG2 must be in 1..10");
    end

    logic [CNT_W-1:0]          cnt;
    logic                      accept;
    logic signed [IN_W-1:0]    x0, x1, x2;
    logic [1:0]                tap_cnt;
    state_t                    state;
    logic                      s0_valid, s0_mode;
    logic signed [D_W-1:0]     e0, e1, e2, d_comb;
    logic signed [D_W-1:0]     d_r, old, out_r, avg;
    logic                      d_valid, d_mode;
    logic [AVG_LOG2-1:0]       rp, wp, fill_cnt;
    logic signed [S_W-1:0]     sum, sum_next, d_ext, old_ext, sub_ext;
    logic                      full_now, out_valid_r, primed_r;

    // With DECIM=1 the counter is pinned at 0 == CNT_LAST, so every valid
    // sample is accepted without a special case.
    assign accept = IN_VALID && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (IN_VALID) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign e0     = {{2{x0[IN_W-1]}}, x0};
    assign e1     = {{2{x1[IN_W-1]}}, x1};
    assign e2     = {{2{x2[IN_W-1]}}, x2};
    assign d_comb = e0 - (e1 <<< 1) + e2;

    assign d_ext    = {{AVG_LOG2{d_r[D_W-1]}}, d_r};
    assign old_ext  = {{AVG_LOG2{old[D_W-1]}}, old};
    assign sub_ext  = (state == FULL) ? old_ext : '0;
    assign sum_next = sum + d_ext - sub_ext;
    assign avg      = D_W'(sum_next >>> AVG_LOG2);
    // The N-th difference written in WIN already completes the window.
    assign full_now = (state == FULL) || (fill_cnt == '1);

    // The read pointer runs one stage ahead of the write pointer, so a read
    // issued alongside a write never targets the slot being written.
    avg_window_ram #(
        .DEPTH (N),
        .W     (D_W)
    ) u_window (
        .CLK     (CLK),
        .wr_en   (d_valid),
        .wr_addr (wp),
        .wr_data (d_r),
        .rd_en   (s0_valid),
        .rd_addr (rp),
        .rd_data (old)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            x0          <= '0;
            x1          <= '0;
            x2          <= '0;
            tap_cnt     <= '0;
            state       <= TAPS;
            s0_valid    <= 1'b0;
            s0_mode     <= 1'b0;
            d_r         <= '0;
            d_valid     <= 1'b0;
            d_mode      <= 1'b0;
            rp          <= '0;
            wp          <= '0;
            fill_cnt    <= '0;
            sum         <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            primed_r    <= 1'b0;
        end else begin
            // Tap stage: shift on each accepted sample.
            s0_valid <= 1'b0;
            if (accept) begin
                x0      <= IN;
                x1      <= x0;
                x2      <= x1;
                s0_mode <= MODE;
                if (state == TAPS) begin
                    if (tap_cnt == 2'd2) begin
                        state    <= WIN;
                        s0_valid <= 1'b1;
                    end else begin
                        tap_cnt <= tap_cnt + 2'd1;
                    end
                end else begin
                    s0_valid <= 1'b1;
                end
            end

            // Difference stage: register d, window read issued alongside.
            d_valid <= s0_valid;
            if (s0_valid) begin
                d_r    <= d_comb;
                d_mode <= s0_mode;
                rp     <= rp + 1'b1;
            end

            // Accumulate stage: window write, running sum, state, outputs.
            out_valid_r <= 1'b0;
            if (d_valid) begin
                wp  <= wp + 1'b1;
                sum <= sum_next;
                if (state == WIN) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == '1) begin
                        state    <= FULL;
                        primed_r <= 1'b1;
                    end
                end
                if (d_mode) begin
                    out_valid_r <= 1'b1;
                    out_r       <= d_r;
                end else if (full_now) begin
                    out_valid_r <= 1'b1;
                    out_r       <= avg;
                end
            end
        end
    end

    assign OUT       = out_r;
    assign OUT_VALID = out_valid_r;
    assign PRIMED    = primed_r;

endmodule
